// File: rtl/spi_pkg.sv
// Shared types for the SPI serial-clock engine: FSM states and SPI mode encodings.
package spi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Mode encoding is {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_div_tick.sv
// Half-period counter: emits a registered one-cycle pulse every `half` enabled cycles.
module spi_div_tick #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] half,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // Count restarts from zero whenever disabled, so every burst begins phase-aligned
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == DIV_W'(half - DIV_W'(1))) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= DIV_W'(cnt + DIV_W'(1));
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI master serial-clock engine: gated SCLK burst of nbits bits in any CPOL/CPHA mode,
// with sample/shift strobes aligned to the cycle each new SCLK level first appears.
module spi_sclk_gen #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] half_div,
  input  logic [CNT_W-1:0] nbits,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             abort,
  output logic             sclk,
  output logic             sample_stb,
  output logic             shift_stb,
  output logic             busy,
  output logic             done
);
  import spi_pkg::*;

  localparam int unsigned EDGE_W = CNT_W + 1;

  state_t             state;
  logic [DIV_W-1:0]   half_q;
  logic [CNT_W-1:0]   nbits_q;
  logic [CNT_W-1:0]   bit_cnt;
  logic [EDGE_W-1:0]  edge_cnt;
  logic               cpol_q;
  logic               cpha_q;
  logic               tick;

  logic               accept_c;
  logic               leading_c;
  logic               last_c;
  logic               div_en_c;
  logic [DIV_W-1:0]   half_sel_c;

  assign accept_c  = (state == IDLE) && start && (nbits != '0);
  assign leading_c = ~edge_cnt[0];
  assign last_c    = ~leading_c && (bit_cnt == CNT_W'(nbits_q - CNT_W'(1)));

  // Divider starts counting on the accept edge so the first toggle lands exactly half cycles later;
  // it is cleared on the final edge so a back-to-back burst restarts at phase zero.
  assign div_en_c   = accept_c || ((state == RUN) && !abort && !(tick && last_c));
  assign half_sel_c = (state == IDLE) ? ((half_div == '0) ? DIV_W'(1) : half_div) : half_q;

  spi_div_tick #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en_c),
    .half (half_sel_c),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      half_q     <= '0;
      nbits_q    <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      bit_cnt    <= '0;
      edge_cnt   <= '0;
      sclk       <= 1'b0;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol_q;
          if (accept_c) begin
            state    <= RUN;
            half_q   <= half_sel_c;
            nbits_q  <= nbits;
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            sclk     <= cpol;
            bit_cnt  <= '0;
            edge_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            sclk  <= cpol_q;
            busy  <= 1'b0;
          end else if (tick) begin
            edge_cnt <= EDGE_W'(edge_cnt + EDGE_W'(1));
            sclk     <= ~sclk;
            if (leading_c) begin
              sample_stb <= ~cpha_q;
              shift_stb  <= cpha_q;
            end else begin
              bit_cnt    <= CNT_W'(bit_cnt + CNT_W'(1));
              sample_stb <= cpha_q;
              shift_stb  <= ~cpha_q && ~last_c;
              if (last_c) begin
                state <= IDLE;
                sclk  <= cpol_q;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
